// File: rtl/pll_ce_gen.sv
// pll_ce_gen: multi-channel fractional clock-enable generator.
// Each channel owns a phase accumulator. The carry out of that accumulator is
// the enable pulse. All channels are gated by a debounced, synchronised PLL lock.
module pll_ce_gen #(
  parameter int unsigned                  CHANNELS    = 4,
  parameter int unsigned                  ACC_W       = 32,
  parameter int unsigned                  LOCK_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0]    INC_INIT    = {CHANNELS{32'h10000000}}
) (
  input  logic                            refclk,
  input  logic                            rst,
  input  logic                            pll_locked,
  input  logic [CHANNELS*ACC_W-1:0]       inc_in,
  input  logic [CHANNELS-1:0]             inc_load,
  input  logic [CHANNELS-1:0]             phase_clr,
  input  logic                            pause,
  output logic [CHANNELS-1:0]             ce,
  output logic                            locked,
  output logic [CHANNELS*ACC_W-1:0]       inc_cur
);

  localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_COUNTING,
    ST_LOCKED
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_sync_meta;
  logic                        r_lk_s;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [ACC_W-1:0]            r_acc [CHANNELS];
  logic [ACC_W:0]              w_sum [CHANNELS];
  logic [CHANNELS*ACC_W-1:0]   r_inc;
  logic [CHANNELS-1:0]         r_ce;
  logic                        w_hold_zero;

  assign locked  = (r_state == ST_LOCKED);
  assign ce      = r_ce;
  assign inc_cur = r_inc;

  // Accumulators are forced to zero whenever lock is absent or is being lost on
  // this edge. This keeps ce low on the same edge that locked falls.
  assign w_hold_zero = !locked || !r_lk_s;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_lk_s      <= 1'b0;
    end else begin
      r_sync_meta <= pll_locked;
      r_lk_s      <= r_sync_meta;
    end
  end

  // Lock debounce counter: clears on lock drop, saturates at LOCK_MAX
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!r_lk_s) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != LOCK_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Lock FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNLOCKED: begin
        if (r_lk_s) begin
          w_state_nxt = (w_cnt_nxt == LOCK_MAX) ? ST_LOCKED : ST_COUNTING;
        end
      end
      ST_COUNTING: begin
        if (!r_lk_s) begin
          w_state_nxt = ST_UNLOCKED;
        end else if (w_cnt_nxt == LOCK_MAX) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!r_lk_s) begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // Lock FSM state and counter registers
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= ST_UNLOCKED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Per-channel sum, one bit wider than the accumulator to expose the carry
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i*ACC_W +: ACC_W]};
    end
  end

  // Increment registers, accumulators and enable pulses
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_inc <= INC_INIT;
      r_ce  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (inc_load[i]) begin
          r_inc[i*ACC_W +: ACC_W] <= inc_in[i*ACC_W +: ACC_W];
        end
        if (w_hold_zero || phase_clr[i]) begin
          r_acc[i] <= '0;
          r_ce[i]  <= 1'b0;
        end else if (pause) begin
          r_ce[i]  <= 1'b0;
        end else begin
          r_acc[i] <= w_sum[i][ACC_W-1:0];
          r_ce[i]  <= w_sum[i][ACC_W];
        end
      end
    end
  end

endmodule
